// File: rtl/mac_drv_pkg.sv
// Shared types for the MAC driver: FSM state encoding.
package mac_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_RESULT = 3'd4
  } mac_drv_state_t;

endpackage

// File: rtl/mac_driver.sv
// Sequences one dot product through an external MAC: clear, feed LEN operand
// pairs, wait out the MAC pipeline, then hand the accumulator to the consumer.
module mac_driver
  import mac_drv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

  mac_drv_state_t state_r;
  mac_drv_state_t state_next_s;
  logic [CW-1:0]  cnt_r;
  logic           flush_r;
  logic           accept_s;
  logic           flush_done_s;

  // Next-state decode; abort overrides everything, including start in IDLE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    flush_done_s = 1'b0;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_next_s = ST_CLR;
          else       state_next_s = ST_IDLE;
        end
        ST_CLR: begin
          state_next_s = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (in_valid) begin
            accept_s = 1'b1;
            if (cnt_r == LAST_C) state_next_s = ST_FLUSH;
            else                 state_next_s = ST_ACCUM;
          end else begin
            state_next_s = ST_ACCUM;
          end
        end
        ST_FLUSH: begin
          // Two cycles: one for the last mac_en, one for mac_cout to settle.
          if (flush_r) begin
            flush_done_s = 1'b1;
            state_next_s = ST_RESULT;
          end else begin
            state_next_s = ST_FLUSH;
          end
        end
        ST_RESULT: begin
          if (res_ready) state_next_s = ST_IDLE;
          else           state_next_s = ST_RESULT;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, handshake flags, MAC commands and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      flush_r   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= {DATA_WIDTH{1'b0}};
      mac_b     <= {DATA_WIDTH{1'b0}};
      res_valid <= 1'b0;
      res_data  <= {(3*DATA_WIDTH){1'b0}};
    end else begin
      state_r   <= state_next_s;
      busy      <= (state_next_s != ST_IDLE);
      in_ready  <= (state_next_s == ST_ACCUM);
      res_valid <= (state_next_s == ST_RESULT);
      flush_r   <= (state_r == ST_FLUSH) && (state_next_s == ST_FLUSH);
      mac_clr   <= (state_r == ST_IDLE) && (state_next_s == ST_CLR);
      mac_en    <= accept_s;
      if (accept_s) begin
        mac_a <= in_a;
        mac_b <= in_b;
        cnt_r <= cnt_r + CW'(1);
      end else if (state_next_s == ST_CLR) begin
        cnt_r <= {CW{1'b0}};
      end
      if (flush_done_s) begin
        res_data <= mac_cout;
      end
    end
  end

endmodule

// File: tb/tb_mac_driver.sv
// Directed bench for mac_driver with behavioural MAC models (LEN=4 and LEN=8).
module tb_mac_driver;

  localparam int DW = 8;
  localparam int RW = 3 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start4 = 1'b0, start8 = 1'b0, abort = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;

  logic busy4, in_ready4, mac_en4, mac_clr4, res_valid4;
  logic [DW-1:0] mac_a4, mac_b4;
  logic [RW-1:0] acc4, res_data4;
  logic busy8, in_ready8, mac_en8, mac_clr8, res_valid8;
  logic [DW-1:0] mac_a8, mac_b8;
  logic [RW-1:0] acc8, res_data8;

  int n_checks = 0;
  int n_fail = 0;
  int en_cnt4 = 0;
  int clr_cnt4 = 0;
  int both_cnt = 0;

  logic [DW-1:0] pa [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [DW-1:0] pb [4] = '{8'd5, 8'd6, 8'd7, 8'd8};

  always #5 clk = ~clk;

  mac_driver #(.DATA_WIDTH(DW), .LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .busy(busy4),
    .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b),
    .mac_en(mac_en4), .mac_clr(mac_clr4), .mac_a(mac_a4), .mac_b(mac_b4),
    .mac_cout(acc4), .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4)
  );

  mac_driver #(.DATA_WIDTH(DW), .LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort), .busy(busy8),
    .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
    .mac_en(mac_en8), .mac_clr(mac_clr8), .mac_a(mac_a8), .mac_b(mac_b8),
    .mac_cout(acc8), .res_valid(res_valid8), .res_ready(res_ready), .res_data(res_data8)
  );

  // Behavioural MACs: synchronous clr/en, registered accumulator, async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc4 <= '0;
    else if (mac_clr4) acc4 <= '0;
    else if (mac_en4)  acc4 <= acc4 + RW'(mac_a4) * RW'(mac_b4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc8 <= '0;
    else if (mac_clr8) acc8 <= '0;
    else if (mac_en8)  acc8 <= acc8 + RW'(mac_a8) * RW'(mac_b8);
  end

  // Command pulse counters.
  always @(posedge clk) begin
    if (mac_en4) en_cnt4 <= en_cnt4 + 1;
    if (mac_clr4) clr_cnt4 <= clr_cnt4 + 1;
    if ((mac_en4 && mac_clr4) || (mac_en8 && mac_clr8)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit sel);
    if (sel) start8 = 1'b1; else start4 = 1'b1;
    tick();
    start4 = 1'b0;
    start8 = 1'b0;
    check("clr_on_start", sel ? mac_clr8 : mac_clr4, 1);
    check("busy_on_start", sel ? busy8 : busy4, 1);
  endtask

  task automatic send_pair(input bit sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic rdy;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = sel ? in_ready8 : in_ready4;
      tick();
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    check("accept", done, 1);
    check("en_after_accept", sel ? mac_en8 : mac_en4, 1);
    check("mac_a", sel ? mac_a8 : mac_a4, a);
  endtask

  task automatic wait_result(input bit sel, output logic [RW-1:0] d, output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (sel ? res_valid8 : res_valid4) lat = k;
    end
    d = sel ? res_data8 : res_data4;
    check("res_timeout", lat != 0, 1);
  endtask

  task automatic finish_result(input bit sel);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_cleared", sel ? res_valid8 : res_valid4, 0);
    check("idle_after_result", sel ? busy8 : busy4, 0);
  endtask

  initial begin
    logic [RW-1:0] d;
    int lat;
    int en0, clr0;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("rst_busy", busy4, 0);
    check("rst_in_ready", in_ready4, 0);
    check("rst_mac_en", mac_en4, 0);
    check("rst_mac_clr", mac_clr4, 0);
    check("rst_mac_a", mac_a4, 0);
    check("rst_res_valid", res_valid4, 0);
    check("rst_res_data", res_data4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("no_cmd_after_reset", mac_en4 | mac_clr4, 0);

    // Back-to-back pairs, exact FLUSH timing
    en0 = en_cnt4; clr0 = clr_cnt4;
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send_pair(1'b0, pa[i], pb[i]);
    check("flush_in_ready", in_ready4, 0);
    tick();
    check("flush_en_low", mac_en4, 0);
    check("flush_no_valid", res_valid4, 0);
    tick();
    check("b2b_res_valid", res_valid4, 1);
    check("b2b_res_data", res_data4, 70);
    check("b2b_en_count", en_cnt4 - en0, 4);
    check("b2b_clr_count", clr_cnt4 - clr0, 1);
    finish_result(1'b0);

    // Gaps of 0..3 cycles between pairs
    en0 = en_cnt4; clr0 = clr_cnt4;
    start_run(1'b0);
    for (int i = 0; i < 4; i++) begin
      send_pair(1'b0, pa[i], pb[i]);
      if (i < 3) begin
        for (int g = 0; g < i; g++) begin
          tick();
          check("gap_en_low", mac_en4, 0);
        end
      end
    end
    wait_result(1'b0, d, lat);
    check("gap_res_data", d, 70);
    check("gap_latency", lat, 2);
    check("gap_en_count", en_cnt4 - en0, 4);
    check("gap_clr_count", clr_cnt4 - clr0, 1);
    finish_result(1'b0);

    // LEN=8, full-scale operands
    start_run(1'b1);
    for (int i = 0; i < 8; i++) send_pair(1'b1, 8'd255, 8'd255);
    wait_result(1'b1, d, lat);
    check("max_res_data", d, 520200);
    check("max_latency", lat, 2);
    finish_result(1'b1);

    // Backpressure on the result, start ignored in RESULT
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send_pair(1'b0, pa[i], pb[i]);
    wait_result(1'b0, d, lat);
    check("hold_first", d, 70);
    for (int i = 0; i < 10; i++) begin
      start4 = (i == 4) ? 1'b1 : 1'b0;
      tick();
      check("hold_valid", res_valid4, 1);
      check("hold_data", res_data4, 70);
      check("hold_no_clr", mac_clr4, 0);
    end
    start4 = 1'b0;
    finish_result(1'b0);
    tick();
    check("start_in_result_ignored", busy4, 0);

    // Abort mid-run, then abort+start in IDLE, then a fresh run
    start_run(1'b0);
    send_pair(1'b0, pa[0], pb[0]);
    send_pair(1'b0, pa[1], pb[1]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy4, 0);
    check("abort_in_ready", in_ready4, 0);
    check("abort_mac_en", mac_en4, 0);
    check("abort_res_valid", res_valid4, 0);
    check("abort_res_data_kept", res_data4, 70);
    check("abort_stale_acc", acc4, 17);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_result", res_valid4, 0);
    end
    start4 = 1'b1;
    abort = 1'b1;
    tick();
    start4 = 1'b0;
    abort = 1'b0;
    check("abort_wins_busy", busy4, 0);
    check("abort_wins_clr", mac_clr4, 0);
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send_pair(1'b0, 8'd1, 8'd1);
    wait_result(1'b0, d, lat);
    check("post_abort_res", d, 4);
    finish_result(1'b0);

    // Asynchronous reset during FLUSH, then a full run
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send_pair(1'b0, pa[i], pb[i]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_mac_en", mac_en4, 0);
    check("arst_mac_a", mac_a4, 0);
    check("arst_mac_b", mac_b4, 0);
    check("arst_res_data", res_data4, 0);
    check("arst_in_ready", in_ready4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_quiet", {busy4, mac_en4, mac_clr4}, 0);
    end
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send_pair(1'b0, pa[i], pb[i]);
    wait_result(1'b0, d, lat);
    check("arst_rerun_res", d, 70);
    check("arst_rerun_latency", lat, 2);
    finish_result(1'b0);

    check("en_clr_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
